multiply: RTL and testbench
===========================

Name: multiply

Overview:
- Signed multiply stage placed directly upstream of the accumulator in the neuron datapath.
- Joins two operand streams (activation `a`, weight `b`) into one product stream, using the team's stb/rdy handshake.
- The output feeds an accumulator's argument port. A burst of products is later summed into one result.
- The block must not insert bubbles inside a burst, because the downstream stage treats a stb gap as end-of-burst.

Parameters:
- ARGW, 16, width of each signed operand.
- RESW, 32, width of the signed result. Legal range: 1 <= RESW <= 2*ARGW.
- SHIFT, 0, arithmetic right shift applied to the full product before narrowing. Legal range: 0 <= SHIFT < 2*ARGW.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- a_stb  in  1  operand A valid
- a_dat  in  ARGW  operand A, signed
- a_rdy  out  1  operand A accepted when a_stb & a_rdy
- b_stb  in  1  operand B valid
- b_dat  in  ARGW  operand B, signed
- b_rdy  out  1  operand B accepted when b_stb & b_rdy
- res_stb  out  1  product valid
- res_dat  out  RESW  product, signed
- res_rdy  in  1  downstream accepts when res_stb & res_rdy

Behaviour:
- **Clocking and reset.** Clock is clk; reset rst is synchronous, active-high. rst clears res_stb, res_dat and the stage-1 valid flag v1 to 0. Operand registers need no reset.
- **Join.**
  - Define advance = ~v1 | ld2, where ld2 = ~res_stb | res_rdy.
  - a_rdy = advance & b_stb; b_rdy = advance & a_stb.
  - Both operands are consumed in the same cycle, or neither is. A lone a_stb or lone b_stb is never accepted.
  - a_rdy/b_rdy are combinational from the partner stb. a_stb/b_stb must not depend combinationally on a_rdy/b_rdy.
- **Stage 1** (operand register):
  - On accept, latch a_dat and b_dat and set v1 = 1.
  - If advance is high and there is no accept, clear v1 to 0.
  - If advance is low, hold.
- **Stage 2** (output register):
  - When ld2 & v1: res_stb <= 1 and res_dat <= narrow(p).
    - p = signed(a) * signed(b), 2*ARGW bits.
    - s = p >>> SHIFT.
  - When ld2 & ~v1: res_stb <= 0.
  - Otherwise hold res_stb and res_dat stable (required while res_stb=1 and res_rdy=0).
- **Latency.** Exactly 2 cycles from the accept edge to res_stb=1 with that pair's product.
- **Throughput.** One pair per cycle. If both stb are held high and res_rdy=1 throughout, res_stb stays high on consecutive cycles with no gaps.
- **Capacity.** At most 2 pairs in flight. Under res_rdy=0 with both stages full, a_rdy and b_rdy are 0.
- **Simultaneous events.** A stage-2 handoff and a new accept in the same cycle are legal and lose nothing. rst has priority over any handshake.
- **Reset mid-operation.** Pairs in flight are discarded; no partial result is emitted. a_rdy/b_rdy reflect the empty pipeline on the cycle after reset.
- **Narrowing, no macro.** narrow(s) = s[RESW-1:0] (two's-complement wrap).
- **Corner case.** Product (-2^(ARGW-1))^2 = 2^(2ARGW-2). It fits in 2*ARGW bits; no special case.

Optional Feature:
- Macro: MULTIPLY_SATURATE_EN.
- **Defined:**
  - If s > 2^(RESW-1)-1, narrow(s) = 2^(RESW-1)-1.
  - If s < -2^(RESW-1), narrow(s) = -2^(RESW-1).
  - Otherwise narrow(s) = s[RESW-1:0].
  - Latency is unchanged; the saturation compare sits in the stage-2 input logic.
- **Undefined:** plain truncation as above; no compare logic is synthesised.

Decomposition:
- Shared package: the saturate function (`sat_narrow`, parameterised by input/output width) and the narrowing-mode constant.
- The same package should also host the stb/rdy handshake helper constants, for reuse by the accumulate/activation stages.
- One natural sub-module, stream_join: 2-input stb/rdy join producing a combined stb and per-input rdy.
- The pipeline registers stay in multiply.

Test Plan:
- **Single pair.** ARGW=16, RESW=32, SHIFT=0: a=3, b=-4, res_rdy=1 -> res_dat=0xFFFFFFF4, res_stb high for exactly 1 cycle, 2 cycles after accept.
- **Back-to-back burst.** Pairs (1,2), (3,4), (5,6), (-7,8) on consecutive cycles, res_rdy=1 -> res_stb high 4 consecutive cycles with 2, 12, 30, -56; no gap.
- **Backpressure.** Hold res_rdy=0 while streaming -> the first product is held stable and a_rdy/b_rdy drop after 2 pairs are in flight. Release res_rdy -> the remaining pairs drain in order, none lost or duplicated.
- **Join.** a_stb=1 with b_stb=0 for 5 cycles -> a_rdy=0 and no res_stb. Raise b_stb -> exactly one accept.
- **Narrowing.** RESW=16, SHIFT=0, a=b=300 -> 0x5F90 without the macro; 0x7FFF with MULTIPLY_SATURATE_EN. Also a=-300, b=300 -> 0x8000 saturated.
- **Reset mid-operation.** Assert rst with 2 pairs in flight -> res_stb=0 the next cycle; no stale product appears after reset; a new pair completes with normal latency.

Source files
------------

// File: rtl/multiply_pkg.sv
// multiply_pkg: shared definitions for the neuron datapath stages.
//
// Contents:
//   - narrow_mode_e / NARROW_MODE : how a wide product is reduced to the
//     result width. WRAP keeps the low bits; SAT clamps to the signed range.
//     NARROW_MODE is SAT when MULTIPLY_SATURATE_EN is defined.
//   - hs_t / hs_fire and HS_* constants : stb/rdy handshake helpers shared
//     by the multiply, accumulate and activation stages.
//   - sat_narrow : signed saturation of a SAT_W-bit value to out_w bits.
//     Callers sign-extend their input to SAT_W bits, so operands up to
//     SAT_W/2 bits wide (products up to SAT_W bits) are supported.
package multiply_pkg;

    typedef enum logic {
        NARROW_WRAP = 1'b0,
        NARROW_SAT  = 1'b1
    } narrow_mode_e;

`ifdef MULTIPLY_SATURATE_EN
    localparam narrow_mode_e NARROW_MODE = NARROW_SAT;
`else
    localparam narrow_mode_e NARROW_MODE = NARROW_WRAP;
`endif

    // A transfer happens on a rising clock edge where stb & rdy are both high.
    // A producer holds stb and data stable until the transfer; stb never
    // depends combinationally on rdy.
    typedef struct packed {
        logic stb;
        logic rdy;
    } hs_t;

    localparam logic HS_IDLE   = 1'b0;
    localparam logic HS_ACTIVE = 1'b1;

    function automatic logic hs_fire(input hs_t h);
        return h.stb & h.rdy;
    endfunction

    localparam int SAT_W = 64;

    function automatic logic signed [SAT_W-1:0] sat_narrow(
        input logic signed [SAT_W-1:0] s,
        input int unsigned             out_w
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = $signed((SAT_W'(1) << (out_w - 1)) - SAT_W'(1));
        // Most negative out_w-bit value is -hi-1, i.e. the bitwise inverse.
        lo = ~hi;
        if (s > hi) begin
            sat_narrow = hi;
        end else if (s < lo) begin
            sat_narrow = lo;
        end else begin
            sat_narrow = s;
        end
    endfunction

endpackage

// File: rtl/multiply_join.sv
// stream_join: combine two stb/rdy input streams into one.
//
// Both inputs transfer together or not at all: each input's rdy requires
// the partner's stb, so a lone stb is never accepted. rdy is combinational
// from the partner's stb and the downstream advance signal.
//
// Ports:
//   a_stb_i, b_stb_i : input stream valids
//   adv_i            : downstream can take a joined item this cycle
//   stb_o            : both inputs valid
//   a_rdy_o, b_rdy_o : per-input ready
module stream_join
    import multiply_pkg::*;
(
    input  logic a_stb_i,
    input  logic b_stb_i,
    input  logic adv_i,
    output logic stb_o,
    output logic a_rdy_o,
    output logic b_rdy_o
);

    assign stb_o   = a_stb_i & b_stb_i;
    assign a_rdy_o = adv_i & b_stb_i;
    assign b_rdy_o = adv_i & a_stb_i;

endmodule

// File: rtl/multiply.sv
// multiply: two-stage signed multiply feeding the accumulator.
//
// Joins an activation stream (a) and a weight stream (b) into a product
// stream. Stage 1 registers the operand pair, stage 2 registers the
// shifted, narrowed product. Two cycles from accept to res_stb, one pair per
// cycle, no bubbles inside a burst (the accumulator reads a stb gap as end
// of burst), at most two pairs in flight.
//
// Handshake: an item moves on a clock edge where stb & rdy are high; the
// producer holds stb/data until then; stb never waits on rdy.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   a_stb/a_dat/a_rdy   : operand A stream, signed ARGW bits
//   b_stb/b_dat/b_rdy   : operand B stream, signed ARGW bits
//   res_stb/res_dat/res_rdy : product stream, signed RESW bits
//
// Parameters: ARGW operand width, RESW result width (1..2*ARGW),
// SHIFT arithmetic right shift of the full product (0..2*ARGW-1).
//
// Build option: MULTIPLY_SATURATE_EN selects saturating narrowing instead
// of two's-complement wrap.
module multiply
    import multiply_pkg::*;
#(
    parameter int ARGW  = 16,
    parameter int RESW  = 32,
    parameter int SHIFT = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            a_stb,
    input  logic [ARGW-1:0] a_dat,
    output logic            a_rdy,
    input  logic            b_stb,
    input  logic [ARGW-1:0] b_dat,
    output logic            b_rdy,
    output logic            res_stb,
    output logic [RESW-1:0] res_dat,
    input  logic            res_rdy
);

    localparam int PW = 2 * ARGW;

    logic            v1_q, v1_d;
    logic [ARGW-1:0] a_q, a_d;
    logic [ARGW-1:0] b_q, b_d;
    logic            res_stb_q, res_stb_d;
    logic [RESW-1:0] res_dat_q, res_dat_d;

    logic ld2;
    logic advance;
    logic join_stb;
    hs_t  join_hs;
    logic accept;

    // Stage 2 can load when empty or being drained this cycle; stage 1 can
    // load when empty or handing off to stage 2. This keeps full throughput
    // under res_rdy=1 and caps occupancy at two pairs under backpressure.
    assign ld2     = ~res_stb_q | res_rdy;
    assign advance = ~v1_q | ld2;

    stream_join u_join (
        .a_stb_i (a_stb),
        .b_stb_i (b_stb),
        .adv_i   (advance),
        .stb_o   (join_stb),
        .a_rdy_o (a_rdy),
        .b_rdy_o (b_rdy)
    );

    assign join_hs = '{stb: join_stb, rdy: advance};
    assign accept  = hs_fire(join_hs);

    logic signed [PW-1:0]   prod;
    logic signed [PW-1:0]   shifted;
    logic        [RESW-1:0] narrowed;

    assign prod    = $signed(a_q) * $signed(b_q);
    assign shifted = prod >>> SHIFT;

`ifdef MULTIPLY_SATURATE_EN
    logic signed [SAT_W-1:0] sat_full;
    assign sat_full = sat_narrow(SAT_W'(shifted), RESW);
    assign narrowed = RESW'(sat_full);
`else
    assign narrowed = RESW'(shifted);
`endif

    always_comb begin
        v1_d      = v1_q;
        a_d       = a_q;
        b_d       = b_q;
        res_stb_d = res_stb_q;
        res_dat_d = res_dat_q;

        if (advance) begin
            v1_d = accept;
        end
        if (accept) begin
            a_d = a_dat;
            b_d = b_dat;
        end
        if (ld2) begin
            res_stb_d = v1_q;
            if (v1_q) begin
                res_dat_d = narrowed;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q      <= 1'b0;
            res_stb_q <= 1'b0;
            res_dat_q <= '0;
        end else begin
            v1_q      <= v1_d;
            res_stb_q <= res_stb_d;
            res_dat_q <= res_dat_d;
        end
    end

    // Operand registers are qualified by v1_q, so they need no reset.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    assign res_stb = res_stb_q;
    assign res_dat = res_dat_q;

endmodule

// File: tb/tb_multiply.sv
// tb_multiply: directed bench for multiply (RESW=32 main instance, plus
// RESW=16 instances with SHIFT=0 and SHIFT=4 sharing the same inputs).
module tb_multiply;
  localparam int ARGW = 16;
  localparam int RESW = 32;

`ifdef MULTIPLY_SATURATE_EN
  localparam logic [15:0] E_N_POS    = 16'h7FFF;
  localparam logic [15:0] E_N_NEG    = 16'h8000;
  localparam logic [15:0] E_N_CORNER = 16'h7FFF;
  localparam logic [15:0] E_S_CORNER = 16'h7FFF;
`else
  localparam logic [15:0] E_N_POS    = 16'h5F90;
  localparam logic [15:0] E_N_NEG    = 16'hA070;
  localparam logic [15:0] E_N_CORNER = 16'h0000;
  localparam logic [15:0] E_S_CORNER = 16'h0000;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic            a_stb, b_stb, a_rdy, b_rdy;
  logic [ARGW-1:0] a_dat, b_dat;
  logic            res_stb, res_rdy;
  logic [RESW-1:0] res_dat;
  logic            n_a_rdy, n_b_rdy, n_stb;
  logic [15:0]     n_dat;
  logic            s_a_rdy, s_b_rdy, s_stb;
  logic [15:0]     s_dat;

  multiply #(.ARGW(ARGW), .RESW(RESW), .SHIFT(0)) dut (
    .clk(clk), .rst(rst),
    .a_stb(a_stb), .a_dat(a_dat), .a_rdy(a_rdy),
    .b_stb(b_stb), .b_dat(b_dat), .b_rdy(b_rdy),
    .res_stb(res_stb), .res_dat(res_dat), .res_rdy(res_rdy)
  );

  multiply #(.ARGW(ARGW), .RESW(16), .SHIFT(0)) dut_n16 (
    .clk(clk), .rst(rst),
    .a_stb(a_stb), .a_dat(a_dat), .a_rdy(n_a_rdy),
    .b_stb(b_stb), .b_dat(b_dat), .b_rdy(n_b_rdy),
    .res_stb(n_stb), .res_dat(n_dat), .res_rdy(res_rdy)
  );

  multiply #(.ARGW(ARGW), .RESW(16), .SHIFT(4)) dut_s4 (
    .clk(clk), .rst(rst),
    .a_stb(a_stb), .a_dat(a_dat), .a_rdy(s_a_rdy),
    .b_stb(b_stb), .b_dat(b_dat), .b_rdy(s_b_rdy),
    .res_stb(s_stb), .res_dat(s_dat), .res_rdy(res_rdy)
  );

  // scoreboard
  int checks = 0;
  int failures = 0;
  int out_cnt = 0;
  int cnt0;
  logic [RESW-1:0] exp_q[$];
  logic [RESW-1:0] cur_exp;
  logic [15:0]     hist;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called with inputs settled before the edge; returns #1 after the edge.
  task automatic cycle();
    if (a_stb && a_rdy && b_stb && b_rdy) exp_q.push_back(cur_exp);
    hist = {hist[14:0], res_stb};
    if (res_stb && res_rdy) begin
      out_cnt++;
      if (exp_q.size() == 0) chk("sb_unexpected_res", 1, 0);
      else chk("sb_res_dat", res_dat, exp_q.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic send_pair(input logic [15:0] a, input logic [15:0] b, input logic [RESW-1:0] e);
    bit done;
    done = 1'b0;
    a_stb = 1'b1;
    b_stb = 1'b1;
    a_dat = a;
    b_dat = b;
    cur_exp = e;
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      done = a_rdy && b_rdy;
      cycle();
    end
    chk("send_accept", done, 1);
  endtask

  task automatic idle(input int n);
    a_stb = 1'b0;
    b_stb = 1'b0;
    repeat (n) begin
      #1;
      cycle();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    a_stb = 1'b0; b_stb = 1'b0; a_dat = '0; b_dat = '0;
    res_rdy = 1'b0; cur_exp = '0; hist = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_res_stb", res_stb, 0);
    chk("reset_res_dat", res_dat, 0);
    rst = 1'b0;

    // lone b_stb: a side ready, b side not
    b_stb = 1'b1;
    #1;
    chk("lone_b_a_rdy", a_rdy, 1);
    chk("lone_b_b_rdy", b_rdy, 0);
    idle(1);

    // single pair, 3 * -4
    res_rdy = 1'b1;
    hist = '0;
    send_pair(16'd3, -16'sd4, 32'hFFFF_FFF4);
    idle(3);
    chk("single_stb_pattern", hist[3:0], 4'b0010);
    chk("single_sb_empty", exp_q.size(), 0);

    // back-to-back burst: 2, 12, 30, -56
    hist = '0;
    cnt0 = out_cnt;
    send_pair(16'd1, 16'd2, 32'd2);
    send_pair(16'd3, 16'd4, 32'd12);
    send_pair(16'd5, 16'd6, 32'd30);
    send_pair(-16'sd7, 16'd8, 32'hFFFF_FFC8);
    idle(4);
    chk("burst_stb_pattern", hist[7:0], 8'h3C);
    chk("burst_count", out_cnt - cnt0, 4);
    chk("burst_sb_empty", exp_q.size(), 0);

    // backpressure: 100, -60, -49, 1000000
    res_rdy = 1'b0;
    cnt0 = out_cnt;
    send_pair(16'd10, 16'd10, 32'd100);
    send_pair(-16'sd20, 16'd3, 32'hFFFF_FFC4);
    a_stb = 1'b1; b_stb = 1'b1;
    a_dat = 16'd7; b_dat = -16'sd7;
    cur_exp = 32'hFFFF_FFCF;
    #1;
    chk("bp_full_a_rdy", a_rdy, 0);
    chk("bp_full_b_rdy", b_rdy, 0);
    chk("bp_res_stb", res_stb, 1);
    chk("bp_res_dat", res_dat, 100);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_hold_dat", res_dat, 100);
      chk("bp_hold_stb", res_stb, 1);
      chk("bp_hold_a_rdy", a_rdy, 0);
    end
    res_rdy = 1'b1;
    send_pair(16'd7, -16'sd7, 32'hFFFF_FFCF);
    send_pair(16'd1000, 16'd1000, 32'd1000000);
    idle(4);
    chk("bp_count", out_cnt - cnt0, 4);
    chk("bp_sb_empty", exp_q.size(), 0);

    // join: lone a_stb for 5 cycles, then b arrives
    cnt0 = out_cnt;
    a_stb = 1'b1; b_stb = 1'b0;
    a_dat = 16'd5; b_dat = 16'd9;
    cur_exp = 32'd45;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("join_lone_a_rdy", a_rdy, 0);
      chk("join_lone_res_stb", res_stb, 0);
      cycle();
    end
    b_stb = 1'b1;
    #1;
    chk("join_pair_a_rdy", a_rdy, 1);
    cycle();
    idle(4);
    chk("join_count", out_cnt - cnt0, 1);
    chk("join_sb_empty", exp_q.size(), 0);

    // narrowing on the 16-bit instances
    send_pair(16'd300, 16'd300, 32'h0001_5F90);
    a_stb = 1'b0; b_stb = 1'b0;
    #1;
    cycle();
    chk("narrow_pos_stb", n_stb, 1);
    chk("narrow_pos_n16", n_dat, E_N_POS);
    chk("narrow_pos_s4", s_dat, 16'h15F9);
    idle(2);
    send_pair(-16'sd300, 16'd300, 32'hFFFE_A070);
    a_stb = 1'b0; b_stb = 1'b0;
    #1;
    cycle();
    chk("narrow_neg_n16", n_dat, E_N_NEG);
    chk("narrow_neg_s4", s_dat, 16'hEA07);
    idle(2);
    send_pair(16'h8000, 16'h8000, 32'h4000_0000);
    a_stb = 1'b0; b_stb = 1'b0;
    #1;
    cycle();
    chk("corner_n16", n_dat, E_N_CORNER);
    chk("corner_s4", s_dat, E_S_CORNER);
    idle(2);
    chk("narrow_sb_empty", exp_q.size(), 0);

    // reset with two pairs in flight
    res_rdy = 1'b0;
    send_pair(16'd11, 16'd11, 32'd121);
    send_pair(16'd12, 16'd12, 32'd144);
    #1;
    chk("rst_pre_full_a_rdy", a_rdy, 0);
    rst = 1'b1;
    a_stb = 1'b0; b_stb = 1'b0;
    exp_q.delete();
    #1;
    cycle();
    chk("rst_mid_res_stb", res_stb, 0);
    chk("rst_mid_res_dat", res_dat, 0);
    rst = 1'b0;
    b_stb = 1'b1;
    #1;
    chk("rst_empty_a_rdy", a_rdy, 1);
    res_rdy = 1'b1;
    hist = '0;
    idle(4);
    chk("rst_no_stale", hist[3:0], 4'b0000);
    hist = '0;
    cnt0 = out_cnt;
    send_pair(16'd6, 16'd7, 32'd42);
    idle(3);
    chk("rst_after_pattern", hist[3:0], 4'b0010);
    chk("rst_after_count", out_cnt - cnt0, 1);
    chk("final_sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
